// File: rtl/data_wb_master.sv
// Wishbone B4 classic master for the CPU data side: turns a single-cycle memory-stage
// request into one bus cycle, stalling the pipeline until ack, flush or timeout.
module data_wb_master #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [1:0]  dbg_state_o  // 0 IDLE, 1 BUSY, 2 WAIT_STALL
);

  // Handshake: cpu_ce_i is the request; the memory stage regards the access as
  // complete at the end of the first cycle in which stallreq_o is low.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        cyc_q, cyc_d;
  logic        timeout;

  assign timeout = (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_buf_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_buf_q <= rd_buf_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_buf_d   = rd_buf_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    sel_d      = sel_q;
    cyc_d      = cyc_q;
    stallreq_o = 1'b0;
    bus_err_o  = 1'b0;
    cpu_data_o = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          addr_d     = cpu_addr_i;
          data_d     = cpu_data_i;
          we_d       = cpu_we_i;
          sel_d      = cpu_sel_i;
          cyc_d      = 1'b1;
          tmo_d      = '0;
          state_d    = BUSY;
          stallreq_o = 1'b1;
        end
      end
      BUSY: begin
        if (wb_ack_i && !we_q) cpu_data_o = wb_data_i;
        // Flush beats ack, and ack beats a timeout landing on the same cycle.
        if (flush_i) begin
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          rd_buf_d = '0;
          state_d  = IDLE;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          rd_buf_d = we_q ? 32'h0 : wb_data_i;
          state_d  = stall_i ? WAIT_STALL : IDLE;
        end else if (timeout) begin
          cyc_d     = 1'b0;
          rd_buf_d  = '0;
          bus_err_o = 1'b1;
          state_d   = stall_i ? WAIT_STALL : IDLE;
        end else begin
          tmo_d      = tmo_q + 8'd1;
          stallreq_o = 1'b1;
        end
      end
      WAIT_STALL: begin
        // Holds the result while the pipeline is frozen so the held request is not re-issued.
        cpu_data_o = rd_buf_q;
        if (flush_i) begin
          rd_buf_d = '0;
          state_d  = IDLE;
        end else if (!stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_addr_o   = addr_q;
  assign wb_data_o   = data_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_stb_o    = cyc_q;
  assign wb_cyc_o    = cyc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_wb_master.sv
// Self-checking bench for data_wb_master: directed scenarios plus randomized
// transactions checked against a transaction-level model of the bus cycle.
module tb_data_wb_master;

  localparam int unsigned T = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, cpu_ce_i, cpu_we_i, wb_ack_i;
  logic [31:0] cpu_addr_i, cpu_data_i, wb_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o, wb_addr_o, wb_data_o;
  logic        stallreq_o, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_bad = 0;

  // {cyc, stb, stallreq, bus_err, cpu_data}
  logic [35:0] obs_v;
  // {we, sel, addr, data}
  logic [68:0] bus_v;
  assign obs_v = {wb_cyc_o, wb_stb_o, stallreq_o, bus_err_o, cpu_data_o};
  assign bus_v = {wb_we_o, wb_sel_o, wb_addr_o, wb_data_o};

  always #5 clk = ~clk;

  data_wb_master #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
    cpu_data_i = '0; wb_ack_i = 1'b0; wb_data_i = '0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = data;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [106:0] ex;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    ex = '0;
    n_cmp++;
    if ({obs_v, bus_v, dbg_state_o} !== ex) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=%h", {obs_v, bus_v, dbg_state_o}, ex);
    end
  endtask

  task automatic test_load_zero_wait();
    logic [35:0] ex;
    logic [68:0] exb;
    tick(); set_req(1'b0, 32'h100, 4'hF, 32'h0);
    @(negedge clk);
    ex = {1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL lzw_req got=%h exp=%h", obs_v, ex); end
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'hDEADBEEF;
    @(negedge clk);
    ex = {1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL lzw_ack got=%h exp=%h", obs_v, ex); end
    exb = {1'b0, 4'hF, 32'h100, 32'h0};
    n_cmp++; if (bus_v !== exb) begin n_bad++; $display("FAIL lzw_bus got=%h exp=%h", bus_v, exb); end
    tick(); idle_inputs();
    @(negedge clk);
    ex = '0;
    n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL lzw_after got=%h exp=%h", obs_v, ex); end
  endtask

  task automatic test_store_wait3();
    logic [35:0] ex;
    logic [68:0] exb;
    int stall_cycles;
    tick(); set_req(1'b1, 32'h2000_0040, 4'b0100, 32'h12345678);
    @(negedge clk);
    stall_cycles = int'(stallreq_o);
    exb = {1'b1, 4'b0100, 32'h2000_0040, 32'h12345678};
    for (int j = 1; j <= 4; j++) begin
      tick(); wb_ack_i = (j == 4); wb_data_i = 32'hA5A5_0000 | j;
      @(negedge clk);
      stall_cycles += int'(stallreq_o);
      ex = {1'b1, 1'b1, (j < 4), 1'b0, 32'h0};
      n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL st3_obs%0d got=%h exp=%h", j, obs_v, ex); end
      n_cmp++; if (bus_v !== exb) begin n_bad++; $display("FAIL st3_hold%0d got=%h exp=%h", j, bus_v, exb); end
    end
    n_cmp++; if (stall_cycles !== 4) begin n_bad++; $display("FAIL st3_stallcnt got=%0d exp=4", stall_cycles); end
    tick(); idle_inputs();
    @(negedge clk);
    n_cmp++; if ({obs_v, wb_we_o} !== 37'h0) begin n_bad++; $display("FAIL st3_after got=%h exp=0", {obs_v, wb_we_o}); end
  endtask

  task automatic test_stall_on_ack();
    logic [37:0] ex;
    tick(); set_req(1'b0, 32'h300, 4'hF, 32'h0);
    tick(); wb_data_i = 32'h1111_1111;
    @(negedge clk);
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'hCAFE_F00D; stall_i = 1'b1;
    @(negedge clk);
    ex = {1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 2'd1};
    n_cmp++; if ({obs_v, dbg_state_o} !== ex) begin n_bad++; $display("FAIL sta_ack got=%h exp=%h", {obs_v, dbg_state_o}, ex); end
    for (int w = 0; w < 3; w++) begin
      tick(); stall_i = (w < 2); cpu_ce_i = (w < 2); wb_ack_i = 1'b1; wb_data_i = 32'h5555_0000 | w;
      @(negedge clk);
      ex = {4'b0, 32'hCAFE_F00D, S_WAIT};
      n_cmp++; if ({obs_v, dbg_state_o} !== ex) begin n_bad++; $display("FAIL sta_wait%0d got=%h exp=%h", w, {obs_v, dbg_state_o}, ex); end
    end
    tick(); idle_inputs();
    @(negedge clk);
    ex = {36'h0, S_IDLE};
    n_cmp++; if ({obs_v, dbg_state_o} !== ex) begin n_bad++; $display("FAIL sta_idle got=%h exp=%h", {obs_v, dbg_state_o}, ex); end
  endtask

  task automatic test_flush();
    logic [35:0] ex;
    tick(); set_req(1'b0, 32'h400, 4'hF, 32'h0);
    tick(); @(negedge clk);
    tick(); flush_i = 1'b1;
    @(negedge clk);
    ex = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL fl_busy got=%h exp=%h", obs_v, ex); end
    tick(); idle_inputs(); wb_ack_i = 1'b1; wb_data_i = 32'hBAD0_BAD0;
    @(negedge clk);
    n_cmp++; if ({obs_v, dbg_state_o} !== 38'h0) begin n_bad++; $display("FAIL fl_next got=%h exp=0", {obs_v, dbg_state_o}); end
    n_cmp++; if (dut.rd_buf_q !== 32'h0) begin n_bad++; $display("FAIL fl_rdbuf got=%h exp=0", dut.rd_buf_q); end
    tick(); wb_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_v !== 36'h0) begin n_bad++; $display("FAIL fl_late_ack got=%h exp=0", obs_v); end
    // flush alongside a request in IDLE
    tick(); set_req(1'b0, 32'h500, 4'hF, 32'h0); flush_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_v !== 36'h0) begin n_bad++; $display("FAIL fl_idle_req got=%h exp=0", obs_v); end
    tick(); idle_inputs();
    @(negedge clk);
    n_cmp++; if (obs_v !== 36'h0) begin n_bad++; $display("FAIL fl_idle_nostb got=%h exp=0", obs_v); end
    // ack and flush together with stall: flush must win, no WAIT_STALL
    tick(); set_req(1'b0, 32'h600, 4'hF, 32'h0);
    tick(); wb_ack_i = 1'b1; wb_data_i = 32'h7777_7777; flush_i = 1'b1; stall_i = 1'b1;
    tick(); idle_inputs(); stall_i = 1'b1;
    @(negedge clk);
    n_cmp++; if ({obs_v, dbg_state_o} !== {36'h0, S_IDLE}) begin n_bad++; $display("FAIL fl_ackflush got=%h exp=0", {obs_v, dbg_state_o}); end
    tick(); idle_inputs();
  endtask

  task automatic test_timeout();
    logic [35:0] ex;
    tick(); set_req(1'b0, 32'h700, 4'hF, 32'h0);
    for (int j = 1; j <= T; j++) begin
      tick(); wb_data_i = 32'hFEED_0000 | j;
      @(negedge clk);
      ex = {1'b1, 1'b1, (j < T), (j == T), 32'h0};
      n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL tmo_c%0d got=%h exp=%h", j, obs_v, ex); end
    end
    tick(); idle_inputs();
    @(negedge clk);
    n_cmp++; if (obs_v !== 36'h0) begin n_bad++; $display("FAIL tmo_after got=%h exp=0", obs_v); end
    // ack landing on the timeout cycle wins
    tick(); set_req(1'b0, 32'h704, 4'hF, 32'h0);
    for (int j = 1; j <= T; j++) begin
      tick(); wb_ack_i = (j == T); wb_data_i = 32'h600D_0000 | j;
      @(negedge clk);
      ex = {1'b1, 1'b1, (j < T), 1'b0, (j == T) ? (32'h600D_0000 | j) : 32'h0};
      n_cmp++; if (obs_v !== ex) begin n_bad++; $display("FAIL tmo_ackwin%0d got=%h exp=%h", j, obs_v, ex); end
    end
    tick(); idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [106:0] ex;
    tick(); set_req(1'b1, 32'h800, 4'h3, 32'h9999_8888);
    tick(); @(negedge clk);
    tick(); idle_inputs(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    ex = '0;
    n_cmp++;
    if ({obs_v, bus_v, dbg_state_o} !== ex) begin
      n_bad++; $display("FAIL rst_mid got=%h exp=%h", {obs_v, bus_v, dbg_state_o}, ex);
    end
  endtask

  // Model: ack after k wait cycles ends the cycle on BUSY cycle k+1 unless that
  // exceeds T, in which case cycle T is an abort with bus error and zero data.
  task automatic test_random();
    logic        we, to, stalled;
    logic [31:0] addr, data, rdata, exp_d;
    logic [3:0]  sel;
    int          k, e, s;
    logic [104:0] exb;
    logic [37:0]  exw;
    for (int t = 0; t < 40; t++) begin
      we = 1'(($urandom_range(0, 1)));
      addr = $urandom(); data = $urandom(); rdata = $urandom();
      sel = 4'($urandom_range(1, 15));
      k = $urandom_range(0, 5);
      stalled = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 2);
      to = (k + 1 > T);
      e = to ? T : k + 1;
      exp_d = (to || we) ? 32'h0 : rdata;

      tick(); idle_inputs(); set_req(we, addr, sel, data);
      @(negedge clk);
      n_cmp++; if (obs_v !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
        n_bad++; $display("FAIL rnd_req t=%0d got=%h exp=%h", t, obs_v, {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
      end
      for (int j = 1; j <= e; j++) begin
        tick();
        wb_ack_i = (j == e) && !to;
        wb_data_i = (j == e) ? rdata : $urandom();
        stall_i = (j == e) && stalled;
        @(negedge clk);
        exb = {1'b1, 1'b1, (j < e), ((j == e) && to), ((j == e) ? exp_d : 32'h0), we, sel, addr, data};
        n_cmp++; if ({obs_v, bus_v} !== exb) begin
          n_bad++; $display("FAIL rnd_busy t=%0d j=%0d got=%h exp=%h", t, j, {obs_v, bus_v}, exb);
        end
      end
      if (stalled) begin
        for (int w = 0; w <= s; w++) begin
          tick();
          stall_i = (w < s); cpu_ce_i = (w < s);
          wb_ack_i = 1'($urandom_range(0, 1)); wb_data_i = $urandom();
          @(negedge clk);
          exw = {4'b0, exp_d, S_WAIT};
          n_cmp++; if ({obs_v, dbg_state_o} !== exw) begin
            n_bad++; $display("FAIL rnd_wait t=%0d w=%0d got=%h exp=%h", t, w, {obs_v, dbg_state_o}, exw);
          end
        end
      end
    end
    tick(); idle_inputs();
    @(negedge clk);
    n_cmp++; if ({obs_v, dbg_state_o} !== {36'h0, S_IDLE}) begin
      n_bad++; $display("FAIL rnd_end got=%h exp=0", {obs_v, dbg_state_o});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_stall_on_ack();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_wb_master.md
# data_wb_master

Wishbone B4 classic master for the data side of the CPU, placed directly downstream of the memory-access stage. It converts the stage's single-cycle RAM request (address, write enable, byte select, write data, chip enable) into a multi-cycle bus transaction. While the transaction is outstanding it raises a pipeline stall request, and it returns read data to the stage for load alignment. A timeout counter aborts cycles that never receive an acknowledge.

## Interface
- ACK_TIMEOUT, 16: cycles BUSY may wait for wb_ack_i before aborting; range 2..255.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  controller holds the memory stage this cycle; excludes this block's own stallreq_o.
- flush_i  in  1  pipeline flush; discards any pending access.
- cpu_ce_i  in  1  access requested by memory stage.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address.
- cpu_sel_i  in  4  byte enables; bit 3 = data[31:24] (big-endian lanes).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data to memory stage.
- stallreq_o  out  1  stall request to controller.
- bus_err_o  out  1  one-cycle pulse on timeout abort.
- wb_data_i  in  32  bus read data.
- wb_ack_i  in  1  bus acknowledge.
- wb_addr_o  out  32  bus address.
- wb_data_o  out  32  bus write data.
- wb_we_o  out  1  bus write enable.
- wb_sel_o  out  4  bus byte select.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.

## Operation
- FSM states: IDLE, BUSY, WAIT_STALL. The FSM also holds a 32-bit rd_buf register and an 8-bit timeout counter tmo.
- **IDLE**
  - If cpu_ce_i=1 and flush_i=0: register cpu_addr/data/we/sel onto the wb_* outputs, set cyc=stb=1, clear tmo, go to BUSY.
  - Otherwise stay in IDLE with cyc=stb=0.
- **BUSY**
  - wb_* outputs are held stable.
  - On wb_ack_i=1: clear cyc/stb/we, capture wb_data_i into rd_buf, then go to WAIT_STALL if stall_i=1, else IDLE.
  - If flush_i=1 (takes priority over ack): clear cyc/stb/we, clear rd_buf, go to IDLE.
  - If tmo reaches ACK_TIMEOUT-1 without ack: clear cyc/stb, set rd_buf=0, pulse bus_err_o, then go to WAIT_STALL if stall_i=1, else IDLE.
  - Otherwise increment tmo.
- **WAIT_STALL**
  - cyc/stb=0.
  - Go to IDLE when stall_i=0 or flush_i=1. On flush, also clear rd_buf.
- stallreq_o is combinational:
  - 1 in IDLE when cpu_ce_i=1 and flush_i=0.
  - 1 in BUSY when wb_ack_i=0, flush_i=0, and no timeout is occurring this cycle.
  - 0 otherwise.
- cpu_data_o is combinational:
  - BUSY with wb_ack_i=1 and wb_we_o=0: wb_data_i.
  - BUSY on the timeout cycle: 0.
  - WAIT_STALL: rd_buf.
  - Otherwise: 0.
  - Store cycles always return 0.
- No byte steering is done here. Lanes pass through unchanged; the memory stage performs alignment and sign extension.
- Only one outstanding transaction is allowed. No new request is accepted outside IDLE.

## Timing
- **Reset:** state=IDLE; rd_buf=0; tmo=0. Outputs: wb_addr_o=0, wb_data_o=0, wb_we_o=0, wb_sel_o=0, wb_stb_o=0, wb_cyc_o=0, bus_err_o=0, stallreq_o=0, cpu_data_o=0.
  - rst asserted mid-transaction drops cyc/stb at the next edge; the slave must tolerate the abandoned cycle.
- **Latency:** the request is seen in cycle N and wb_stb_o rises at N+1. If ack arrives at N+1+k, load data is valid on cpu_data_o in that same cycle and the pipeline advances at the end of it.
  - Minimum total is 2 cycles (k=0), i.e. one stall cycle.
- **Bus hold:** wb_addr_o, wb_data_o, wb_sel_o and wb_we_o must not change while wb_stb_o=1.
- **Back-to-back requests:** after ack the FSM returns to IDLE. The next request starts in the following cycle, so wb_stb_o is low for at least one cycle between transactions.
- **WAIT_STALL:** prevents a held instruction (cpu_ce_i still 1) from being re-issued on the bus.
- **ack and flush in the same cycle:** flush wins; data is discarded.
- **ack on the timeout cycle:** ack wins; bus_err_o stays 0.
- **Spurious wb_ack_i in IDLE or WAIT_STALL:** ignored.

## Test plan
- **Load, zero-wait:** cpu_ce=1, we=0, addr=0x100, sel=4'hF; slave acks with 0xDEADBEEF in the first stb cycle. Required: stallreq=1 for exactly 1 cycle; cpu_data_o=0xDEADBEEF in the ack cycle; cyc=0 on the next cycle.
- **Store, 3 wait states:** we=1, data=0x12345678, sel=4'b0100. Required: wb_* held stable for 4 cycles; stallreq high 4 cycles; cpu_data_o=0.
- **External stall on ack:** load with stall_i=1 during ack and for 2 more cycles. Required: FSM in WAIT_STALL; cpu_data_o=rd_buf during those cycles; no second stb while cpu_ce_i stays 1; IDLE after stall_i falls.
- **Flush mid-BUSY:** flush_i=1 at wait cycle 2. Required: cyc/stb=0 next cycle; stallreq=0; rd_buf=0; a late ack is ignored.
- **Timeout:** ACK_TIMEOUT=4, slave never acks. Required: bus_err_o pulses once on the 4th BUSY cycle; cpu_data_o=0; stallreq falls; cyc drops.
- **Reset mid-transaction:** assert rst during BUSY. Required: every output 0 at the next edge and state=IDLE.
